// File: rtl/s2p_pkg.sv
// Shared types and frame-length helper for the serial_to_parallel deserializer.
// Optional parity framing is selected with the S2P_PARITY_EN macro.
package s2p_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Bits per received frame: data bits, plus one parity bit when enabled.
    function automatic int unsigned frame_len(input int unsigned width);
`ifdef S2P_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// One-entry output holding register with valid/ready handshake.
// A word completed while full and not ready is dropped and sets sticky overflow.
module s2p_out_reg
    import s2p_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] data,
    input  logic          ready_i,
    output logic [DW-1:0] parallel_o,
    output logic          valid_o,
    output logic          overflow_o
);

    out_state_t    r_state;
    out_state_t    w_state_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            EMPTY: begin
                if (load) begin
                    w_state_nxt = FULL;
                    w_data_nxt  = data;
                end
            end
            FULL: begin
                if (ready_i) begin
                    if (load) begin
                        w_data_nxt = data;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end else if (load) begin
                    w_ovf_nxt = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    assign parallel_o = r_data;
    assign valid_o    = (r_state == FULL);
    assign overflow_o = r_ovf;

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer: reassembles WIDTH-bit words from a qualified bit stream.
// Define S2P_PARITY_EN for WIDTH+1-bit frames with a trailing even-parity bit and parity_err_o.
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overflow_o
`ifdef S2P_PARITY_EN
    ,
    output logic             parity_err_o
`endif
);

    localparam int unsigned    FRAME = frame_len(WIDTH);
    localparam int unsigned    CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_done;
    logic             w_is_data;

`ifdef S2P_PARITY_EN
    localparam int unsigned DW = WIDTH + 1;
    assign w_is_data = (r_cnt != CNT_W'(WIDTH));
`else
    localparam int unsigned DW = WIDTH;
    assign w_is_data = 1'b1;
`endif

    logic [DW-1:0] w_load_data;
    logic [DW-1:0] w_out;

    always_comb begin
        if (LSB_FIRST) begin
            w_shift_nxt = (r_shift >> 1) | (WIDTH'(serial_i) << (WIDTH - 1));
        end else begin
            w_shift_nxt = (r_shift << 1) | WIDTH'(serial_i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            IDLE, SHIFT: begin
                if (valid_i) begin
                    if (r_cnt == LAST) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = SHIFT;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (valid_i && w_is_data) begin
                r_shift <= w_shift_nxt;
            end
        end
    end

    // The completing bit is folded in combinationally so the word loads on that same edge.
`ifdef S2P_PARITY_EN
    assign w_load_data  = {(^r_shift) ^ serial_i, r_shift};
    assign parallel_o   = w_out[WIDTH-1:0];
    assign parity_err_o = w_out[WIDTH];
`else
    assign w_load_data  = w_shift_nxt;
    assign parallel_o   = w_out;
`endif

    s2p_out_reg #(
        .DW(DW)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (w_done),
        .data      (w_load_data),
        .ready_i   (ready_i),
        .parallel_o(w_out),
        .valid_o   (valid_o),
        .overflow_o(overflow_o)
    );

    assign busy_o = (r_state == SHIFT);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: LSB-first and MSB-first instances fed the same stream,
// directed vector table, hand-written corner sequences and a randomized model check.
`timescale 1ns/1ps
module tb_serial_to_parallel;

    localparam int W = 4;
`ifdef S2P_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serial_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [W-1:0] par0, par1;
    logic         vo0, vo1, busy0, busy1, ovf0, ovf1;
`ifdef S2P_PARITY_EN
    logic         perr0, perr1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: bits of the frame in progress and the output register
    bit           m_q[$];
    logic [W-1:0] m_lsb, m_msb;
    bit           m_full, m_ovf, m_perr;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(W), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i), .ready_i(ready_i),
        .parallel_o(par0), .valid_o(vo0), .busy_o(busy0), .overflow_o(ovf0)
`ifdef S2P_PARITY_EN
        , .parity_err_o(perr0)
`endif
    );

    serial_to_parallel #(.WIDTH(W), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i), .ready_i(ready_i),
        .parallel_o(par1), .valid_o(vo1), .busy_o(busy1), .overflow_o(ovf1)
`ifdef S2P_PARITY_EN
        , .parity_err_o(perr1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit s, input bit v, input bit r);
        serial_i = s;
        valid_i  = v;
        ready_i  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_lsb  = '0;
        m_msb  = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit v, input bit r);
        bit           done;
        logic [W-1:0] wl, wm;
        bit           pe;
        done = 1'b0;
        if (v) begin
            m_q.push_back(s);
            if (m_q.size() == FL) done = 1'b1;
        end
        if (done) begin
            wl = '0;
            wm = '0;
            pe = 1'b0;
            for (int k = 0; k < W; k++) begin
                wl[k]       = m_q[k];
                wm[W-1-k]   = m_q[k];
            end
            for (int k = 0; k < FL; k++) pe ^= m_q[k];
            m_q.delete();
            if (!m_full || r) begin
                m_full = 1'b1;
                m_lsb  = wl;
                m_msb  = wm;
                m_perr = pe;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_full && r) begin
            m_full = 1'b0;
        end
    endtask

    task automatic model_check();
        check("rnd par lsb", par0, m_lsb);
        check("rnd par msb", par1, m_msb);
        check("rnd valid lsb", vo0, m_full);
        check("rnd valid msb", vo1, m_full);
        check("rnd busy", busy0, m_q.size() != 0);
        check("rnd busy msb", busy1, m_q.size() != 0);
        check("rnd overflow", ovf0, m_ovf);
        check("rnd overflow msb", ovf1, m_ovf);
`ifdef S2P_PARITY_EN
        if (m_full) check("rnd parity_err", perr0, m_perr);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " par"}, par0, 0);
        check({tag, " par msb"}, par1, 0);
        check({tag, " valid"}, vo0, 0);
        check({tag, " busy"}, busy0, 0);
        check({tag, " overflow"}, ovf0, 0);
`ifdef S2P_PARITY_EN
        check({tag, " parity_err"}, perr0, 0);
`endif
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        serial_i = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         s, v, r;
        logic [3:0] par, parm;
        bit         vo, busy, ovf;
    } vec_t;

    vec_t tbl[23];

    initial begin
        tbl = '{
            '{1, 1, 1, 4'h0, 4'h0, 0, 1, 0},
            '{0, 1, 1, 4'h0, 4'h0, 0, 1, 0},
            '{1, 1, 1, 4'h0, 4'h0, 0, 1, 0},
            '{1, 1, 1, 4'hD, 4'hB, 1, 0, 0},
            '{0, 0, 1, 4'hD, 4'hB, 0, 0, 0},
            '{1, 1, 1, 4'hD, 4'hB, 0, 1, 0},
            '{0, 1, 1, 4'hD, 4'hB, 0, 1, 0},
            '{1, 1, 1, 4'hD, 4'hB, 0, 1, 0},
            '{1, 1, 1, 4'hD, 4'hB, 1, 0, 0},
            '{1, 1, 1, 4'hD, 4'hB, 0, 1, 0},
            '{1, 1, 1, 4'hD, 4'hB, 0, 1, 0},
            '{0, 1, 1, 4'hD, 4'hB, 0, 1, 0},
            '{0, 1, 1, 4'h3, 4'hC, 1, 0, 0},
            '{0, 1, 0, 4'h3, 4'hC, 1, 1, 0},
            '{1, 1, 0, 4'h3, 4'hC, 1, 1, 0},
            '{0, 1, 0, 4'h3, 4'hC, 1, 1, 0},
            '{1, 1, 1, 4'hA, 4'h5, 1, 0, 0},
            '{1, 1, 0, 4'hA, 4'h5, 1, 1, 0},
            '{0, 1, 0, 4'hA, 4'h5, 1, 1, 0},
            '{1, 1, 0, 4'hA, 4'h5, 1, 1, 0},
            '{0, 1, 0, 4'hA, 4'h5, 1, 0, 1},
            '{0, 0, 1, 4'hA, 4'h5, 0, 0, 1},
            '{0, 0, 1, 4'hA, 4'h5, 0, 0, 1}
        };

        do_reset();

`ifndef S2P_PARITY_EN
        // Directed table: basic word, back-to-back stream, hold, overflow
        for (int i = 0; i < 23; i++) begin
            tick(tbl[i].s, tbl[i].v, tbl[i].r);
            check($sformatf("tbl%0d par", i), par0, tbl[i].par);
            check($sformatf("tbl%0d par msb", i), par1, tbl[i].parm);
            check($sformatf("tbl%0d valid", i), vo0, tbl[i].vo);
            check($sformatf("tbl%0d busy", i), busy0, tbl[i].busy);
            check($sformatf("tbl%0d overflow", i), ovf0, tbl[i].ovf);
        end

        // Gaps between bits keep the partial word
        do_reset();
        begin
            bit bits[4] = '{1, 0, 1, 1};
            for (int i = 0; i < 4; i++) begin
                tick(bits[i], 1'b1, 1'b0);
                if (i < 3) begin
                    for (int g = 0; g < 3; g++) begin
                        tick(1'b0, 1'b0, 1'b0);
                        check("gap busy", busy0, 1);
                        check("gap valid", vo0, 0);
                    end
                end
            end
        end
        check("gap par", par0, 4'hD);
        check("gap par msb", par1, 4'hB);
        check("gap valid done", vo0, 1);
        check("gap busy done", busy0, 0);

        // Asynchronous reset mid-frame while a word is held
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("prereset busy", busy0, 1);
        check("prereset valid", vo0, 1);
        #3 reset = 1'b0;
        #1;
        check_all_zero("async reset");
        #1 reset = 1'b1;
        model_reset();
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("after reset par", par0, 4'h8);
        check("after reset par msb", par1, 4'h1);
        check("after reset valid", vo0, 1);
`else
        // Parity frames: 1,0,1,1 has odd data parity, so parity bit 1 is good
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("par data not yet valid", vo0, 0);
        check("par bit busy", busy0, 1);
        tick(1'b1, 1'b1, 1'b1);
        check("par good word", par0, 4'hD);
        check("par good word msb", par1, 4'hB);
        check("par good valid", vo0, 1);
        check("par good err", perr0, 0);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("par bad word", par0, 4'hD);
        check("par bad valid", vo0, 1);
        check("par bad err", perr0, 1);
        check("par bad err msb", perr1, 1);
`endif

        // Randomized stream against the reference model, several ready densities
        for (int blk = 0; blk < 4; blk++) begin
            int unsigned rdy_pct;
            rdy_pct = (blk == 0) ? 30 : (blk == 1) ? 60 : (blk == 2) ? 90 : 100;
            do_reset();
            for (int c = 0; c < 250; c++) begin
                bit s, v, r;
                s = 1'($urandom_range(0, 1));
                v = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < rdy_pct);
                tick(s, v, r);
                model_edge(s, v, r);
                model_check();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
